// File: rtl/ifu_prefetch.sv
// ifu_prefetch
//   Instruction fetch unit with an in-order prefetch queue between instruction
//   memory and decode. Sequential fetch requests are issued while there is room
//   for their responses. Returned instructions are queued with their PCs. A
//   branch redirect flushes the queue, and responses still in flight from the
//   old stream are discarded.
//
// Ports
//   clk, resetn              rising-edge clock, asynchronous active-low reset
//   doBranch, branchAdr      redirect fetch to branchAdr and flush the queue
//   stall                    decode not accepting; the head entry is held
//   imem_req, imem_addr      fetch request and its address
//   imem_ready               request accepted when imem_req & imem_ready
//   imem_rvalid, imem_rdata  in-order fetch responses
//   IR, PC, InstrRd          head instruction, its address, valid flag
module ifu_prefetch #(
  parameter int                     PC_WIDTH  = 32,
  parameter int                     INS_WIDTH = 32,
  parameter int                     DEPTH     = 4,
  parameter logic [PC_WIDTH-1:0]    RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 doBranch,
  input  logic [PC_WIDTH-1:0]  branchAdr,
  input  logic                 stall,
  output logic                 imem_req,
  output logic [PC_WIDTH-1:0]  imem_addr,
  input  logic                 imem_ready,
  input  logic                 imem_rvalid,
  input  logic [INS_WIDTH-1:0] imem_rdata,
  output logic [INS_WIDTH-1:0] IR,
  output logic [PC_WIDTH-1:0]  PC,
  output logic                 InstrRd
);

  localparam int                  CW      = $clog2(DEPTH + 1);
  localparam int                  PW      = $clog2(DEPTH);
  localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(INS_WIDTH / 8);
  localparam logic [CW:0]         DEPTH_C = (CW + 1)'(DEPTH);

  logic [PC_WIDTH-1:0]  fetch_pc_q, fetch_pc_d;
  logic [PC_WIDTH-1:0]  resp_pc_q, resp_pc_d;
  logic [CW-1:0]        count_q, count_d;
  logic [CW-1:0]        outst_q, outst_d;
  logic [CW-1:0]        drop_q, drop_d;
  logic [PW-1:0]        head_q, head_d;
  logic [PW-1:0]        tail_q, tail_d;
  logic [PC_WIDTH-1:0]  pc_mem_q  [DEPTH];
  logic [PC_WIDTH-1:0]  pc_mem_d  [DEPTH];
  logic [INS_WIDTH-1:0] ins_mem_q [DEPTH];
  logic [INS_WIDTH-1:0] ins_mem_d [DEPTH];

  logic credit;
  logic accept;
  logic pop;
  logic push;
  logic discard;

  // A request is only issued when the queue has room for every response that
  // could come back, so a response never finds the queue full. The request is
  // also held low while reset is asserted.
  assign credit    = ({1'b0, count_q} + {1'b0, outst_q}) < DEPTH_C;
  assign imem_req  = resetn & ~doBranch & credit;
  assign imem_addr = fetch_pc_q;
  assign accept    = imem_req & imem_ready;

  assign InstrRd   = (count_q != '0);
  assign pop       = InstrRd & ~stall;
  assign discard   = imem_rvalid & (drop_q != '0);
  assign push      = imem_rvalid & (drop_q == '0) & ~doBranch;

  assign IR = InstrRd ? ins_mem_q[head_q] : '0;
  assign PC = InstrRd ? pc_mem_q[head_q]  : '0;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    count_d    = count_q;
    outst_d    = outst_q;
    drop_d     = drop_q;
    head_d     = head_q;
    tail_d     = tail_q;
    pc_mem_d   = pc_mem_q;
    ins_mem_d  = ins_mem_q;

    if (doBranch) begin
      // No request can be accepted in a branch cycle. Every response still in
      // flight after this cycle belongs to the old stream and must be dropped.
      fetch_pc_d = branchAdr;
      resp_pc_d  = branchAdr;
      count_d    = '0;
      head_d     = '0;
      tail_d     = '0;
      outst_d    = outst_q - CW'(imem_rvalid);
      drop_d     = outst_q - CW'(imem_rvalid);
    end else begin
      if (accept) begin
        fetch_pc_d = fetch_pc_q + PC_STEP;
      end
      outst_d = outst_q + CW'(accept) - CW'(imem_rvalid);
      if (discard) begin
        drop_d = drop_q - CW'(1);
      end
      if (push) begin
        pc_mem_d[tail_q]  = resp_pc_q;
        ins_mem_d[tail_q] = imem_rdata;
        tail_d            = tail_q + PW'(1);
        resp_pc_d         = resp_pc_q + PC_STEP;
      end
      if (pop) begin
        head_d = head_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      count_q    <= '0;
      outst_q    <= '0;
      drop_q     <= '0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

  // Queue storage needs no reset: entries are only visible once counted.
  always_ff @(posedge clk) begin
    pc_mem_q  <= pc_mem_d;
    ins_mem_q <= ins_mem_d;
  end

endmodule
